row_window_bank: RTL and testbench

//  Parametrised successor of the 3-row register fill stage. Holds ROWS row registers of REGS_NUM bytes each.

---
 rtl/row_window_bank.sv | 189 ++++++++++++++++++
 tb/tb_row_window_bank.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/row_window_bank.sv
// Row register bank: fills ROWS byte rows from the line-buffer stream, then streams KMAX-wide stride-s windows.
// Windows at 1/cycle after fill_last; fill stalls during SHIFT. ROW_BANK_STALL_CNT_EN adds stall_cnt.
module row_window_bank #(
  parameter int ROWS     = 3,
  parameter int REGS_NUM = 70,
  parameter int PIX      = 32,
  parameter int KMAX     = 3,
  localparam int RSW     = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [3:0]             cfg_k,
  input  logic [3:0]             cfg_s,
  input  logic                   fill_valid,
  output logic                   fill_ready,
  input  logic [RSW-1:0]         fill_row_sel,
  input  logic                   fill_row_valid,
  input  logic [15:0]            fill_start_idx,
  input  logic [15:0]            fill_end_idx,
  input  logic [3:0]             fill_slab_num,
  input  logic [3:0]             fill_west_pad,
  input  logic [3:0]             fill_east_pad,
  input  logic [PIX*8-1:0]       fill_pixels,
  input  logic [15:0]            fill_slab,
  input  logic                   fill_last,
  output logic                   win_valid,
  input  logic                   win_ready,
  output logic [ROWS*KMAX*8-1:0] win_data,
  output logic                   win_last,
  output logic                   cfg_err,
  output logic                   busy
`ifdef ROW_BANK_STALL_CNT_EN
  ,
  output logic [31:0]            stall_cnt
`endif
);

  localparam int RW = REGS_NUM * 8;

  typedef enum logic [1:0] {IDLE, FILL, SHIFT} state_t;

  state_t      state_q, state_d;
  logic [3:0]  k_q, k_d, s_q, s_d;
  logic [15:0] nwin_q, nwin_d, winc_q, winc_d;
  logic        cfg_err_q, cfg_err_d;

  logic        fill_acc, win_hs, first_beat, cfg_bad;
  logic [3:0]  k_eff, s_eff;
  logic [16:0] end_sum;
  logic [15:0] used_len, nwin_calc;
  logic [31:0] st_u, en_u, ea_u, sl_u;
  logic [RW-1:0] wmask, wval;
  logic        unused_west;

  assign unused_west = ^fill_west_pad;

  assign fill_ready = (state_q != SHIFT);
  assign win_valid  = (state_q == SHIFT);
  assign win_last   = win_valid && (winc_q == nwin_q - 16'd1);
  assign busy       = (state_q != IDLE);
  assign cfg_err    = cfg_err_q;
  assign fill_acc   = fill_valid && fill_ready;
  assign win_hs     = win_valid && win_ready;
  assign first_beat = fill_acc && (state_q == IDLE);

  // A single-beat row set must see its own cfg, not the stale registered one.
  assign k_eff     = first_beat ? cfg_k : k_q;
  assign s_eff     = first_beat ? ((cfg_s == 4'd0) ? 4'd1 : cfg_s) : s_q;
  assign end_sum   = {1'b0, fill_end_idx} + 17'(fill_east_pad);
  assign used_len  = (end_sum > 17'(REGS_NUM)) ? 16'(REGS_NUM) : end_sum[15:0];
  assign nwin_calc = (used_len < 16'(k_eff)) ? 16'd0
                   : (used_len - 16'(k_eff)) / 16'(s_eff) + 16'd1;
  assign cfg_bad   = (nwin_calc == 16'd0) || (k_eff == 4'd0) || (32'(k_eff) > 32'(KMAX));

  assign st_u = 32'(fill_start_idx);
  assign en_u = 32'(fill_end_idx);
  assign ea_u = 32'(fill_east_pad);
  assign sl_u = (fill_slab_num > 4'd2) ? 32'd2 : 32'(fill_slab_num);

  // Per-byte overwrite mask/value for the beat; east pad beats slab beats pixels.
  for (genvar b = 0; b < REGS_NUM; b++) begin : g_byte
    logic [31:0] bi1, pidx;
    logic        pix_hit, slab_hit, east_hit;
    assign bi1      = 32'(b) + 32'd1;
    assign pidx     = bi1 - st_u;
    assign pix_hit  = (bi1 >= st_u) && (bi1 <= en_u) && (pidx < 32'(PIX));
    assign slab_hit = (32'(b) < sl_u);
    assign east_hit = (32'(b) >= en_u) && (32'(b) < en_u + ea_u);
    assign wmask[b*8 +: 8] = {8{!fill_row_valid || pix_hit || slab_hit || east_hit}};
    assign wval[b*8 +: 8]  = (!fill_row_valid || east_hit) ? 8'd0
                           : slab_hit ? 8'(fill_slab >> (b*8))
                           : pix_hit  ? 8'(fill_pixels >> (pidx*8))
                           : 8'd0;
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [RW-1:0] row_q, row_d;
    logic          sel;
    assign sel = fill_acc && (32'(fill_row_sel) == 32'(r));

    always_comb begin
      row_d = row_q;
      if (win_hs)     row_d = row_q >> {s_q, 3'b000};
      if (first_beat) row_d = '0;
      if (sel)        row_d = (row_d & ~wmask) | wval;
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) row_q <= '0;
      else        row_q <= row_d;
    end

    for (genvar c = 0; c < KMAX; c++) begin : g_col
      assign win_data[(r*KMAX+c)*8 +: 8] = (32'(c) < 32'(k_q)) ? row_q[c*8 +: 8] : 8'd0;
    end
  end

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    s_d       = s_q;
    nwin_d    = nwin_q;
    winc_d    = winc_q;
    cfg_err_d = 1'b0;
    unique case (state_q)
      IDLE, FILL: begin
        if (fill_acc) begin
          if (first_beat) begin
            state_d = FILL;
            k_d     = cfg_k;
            s_d     = s_eff;
            winc_d  = '0;
            nwin_d  = '0;
          end
          if (fill_last) begin
            if (cfg_bad) begin
              state_d   = IDLE;
              cfg_err_d = 1'b1;
            end else begin
              state_d = SHIFT;
              nwin_d  = nwin_calc;
              winc_d  = '0;
            end
          end
        end
      end
      SHIFT: begin
        if (win_hs) begin
          if (win_last) begin
            state_d = IDLE;
            winc_d  = '0;
          end else begin
            winc_d = winc_q + 16'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      k_q       <= '0;
      s_q       <= '0;
      nwin_q    <= '0;
      winc_q    <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      s_q       <= s_d;
      nwin_q    <= nwin_d;
      winc_q    <= winc_d;
      cfg_err_q <= cfg_err_d;
    end
  end

`ifdef ROW_BANK_STALL_CNT_EN
  logic [31:0] stall_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                        stall_q <= '0;
    else if (first_beat)                               stall_q <= '0;
    else if (win_valid && !win_ready && stall_q != '1) stall_q <= stall_q + 32'd1;
  end
  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_row_window_bank.sv
// Directed bench for row_window_bank: table of fill configurations plus hand sequences for stall/reset/fill-in-SHIFT.
module tb_row_window_bank;
  localparam int ROWS = 3, REGS_NUM = 70, PIX = 32, KMAX = 3;
  localparam int WW = ROWS * KMAX * 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [3:0]    cfg_k = '0, cfg_s = '0;
  logic          fill_valid = 1'b0, fill_ready;
  logic [1:0]    fill_row_sel = '0;
  logic          fill_row_valid = 1'b0;
  logic [15:0]   fill_start_idx = '0, fill_end_idx = '0;
  logic [3:0]    fill_slab_num = '0, fill_west_pad = '0, fill_east_pad = '0;
  logic [PIX*8-1:0] fill_pixels = '0;
  logic [15:0]   fill_slab = '0;
  logic          fill_last = 1'b0;
  logic          win_valid, win_ready = 1'b0, win_last, cfg_err, busy;
  logic [WW-1:0] win_data;
`ifdef ROW_BANK_STALL_CNT_EN
  logic [31:0]   stall_cnt;
`endif

  always #5 clk = ~clk;

  row_window_bank #(.ROWS(ROWS), .REGS_NUM(REGS_NUM), .PIX(PIX), .KMAX(KMAX)) dut (
    .clk(clk), .reset(reset), .cfg_k(cfg_k), .cfg_s(cfg_s),
    .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_row_sel(fill_row_sel),
    .fill_row_valid(fill_row_valid), .fill_start_idx(fill_start_idx), .fill_end_idx(fill_end_idx),
    .fill_slab_num(fill_slab_num), .fill_west_pad(fill_west_pad), .fill_east_pad(fill_east_pad),
    .fill_pixels(fill_pixels), .fill_slab(fill_slab), .fill_last(fill_last),
    .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data), .win_last(win_last),
    .cfg_err(cfg_err), .busy(busy)
`ifdef ROW_BANK_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  typedef struct packed {
    int k; int s; int st; int en; int ea;
    int rmask; int r0v; int ghost; int nwin; int err;
  } vec_t;

  vec_t tbl [11];
  int   n_chk = 0;
  int   n_pass = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic vec_t mk(int k, int s, int st, int en, int ea, int rmask, int r0v,
                              int ghost, int nwin, int err);
    vec_t v;
    v.k = k; v.s = s; v.st = st; v.en = en; v.ea = ea;
    v.rmask = rmask; v.r0v = r0v; v.ghost = ghost; v.nwin = nwin; v.err = err;
    return v;
  endfunction

  function automatic logic [7:0] pix(int r, int i);
    return 8'(r * 64 + i + 1);
  endfunction

  function automatic logic [7:0] slab(int r, int b);
    return (b == 0) ? 8'(224 + r) : 8'(240 + r);
  endfunction

  // Expected row content right after the fill of vector v (rows start cleared).
  function automatic logic [7:0] exp_byte(vec_t v, int r, int b);
    if (((v.rmask >> r) & 1) == 0) return 8'd0;
    if (r == 0 && v.r0v == 0) return 8'd0;
    if (b >= v.en && b < v.en + v.ea) return 8'd0;
    if (b < 2) return slab(r, b);
    if (b + 1 >= v.st && b + 1 <= v.en && b + 1 - v.st < PIX) return pix(r, b + 1 - v.st);
    return 8'd0;
  endfunction

  function automatic logic [WW-1:0] exp_win(vec_t v, int j);
    logic [WW-1:0] w;
    int s;
    w = '0;
    s = (v.s == 0) ? 1 : v.s;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < KMAX; c++)
        if (c < v.k && j * s + c < REGS_NUM)
          w = w | (WW'(exp_byte(v, r, j * s + c)) << ((r * KMAX + c) * 8));
    return w;
  endfunction

  task automatic beat(input vec_t v, input int r, input int last);
    logic [PIX*8-1:0] px;
    px = '0;
    for (int i = 0; i < PIX; i++) px = px | ((PIX*8)'(pix(r, i)) << (i * 8));
    cfg_k          = 4'(v.k);
    cfg_s          = 4'(v.s);
    fill_valid     = 1'b1;
    fill_row_sel   = 2'(r);
    fill_row_valid = (r == 0 && v.r0v == 0) ? 1'b0 : 1'b1;
    fill_start_idx = 16'(v.st);
    fill_end_idx   = 16'(v.en);
    fill_slab_num  = 4'd2;
    fill_west_pad  = 4'd0;
    fill_east_pad  = 4'(v.ea);
    fill_pixels    = px;
    fill_slab      = {slab(r, 1), slab(r, 0)};
    fill_last      = (last != 0);
    @(negedge clk);
    fill_valid = 1'b0;
    fill_last  = 1'b0;
  endtask

  task automatic fill_set(input vec_t v);
    int last_r;
    last_r = 0;
    for (int r = 0; r < ROWS; r++) if (((v.rmask >> r) & 1) != 0) last_r = r;
    if (v.ghost != 0) beat(v, 3, 0);
    for (int r = 0; r < ROWS; r++)
      if (((v.rmask >> r) & 1) != 0) beat(v, r, (r == last_r) ? 1 : 0);
  endtask

  task automatic consume(input vec_t v, input int j0, input int maxn, input string tag,
                         output int got);
    int derr, lerr;
    bit done;
    derr = 0; lerr = 0; done = 1'b0; got = 0;
    win_ready = 1'b1;
    for (int t = 0; t < maxn + 20 && !done && got < maxn; t++) begin
      if (win_valid) begin
        if (win_data !== exp_win(v, j0 + got)) derr++;
        if (win_last !== ((j0 + got) == v.nwin - 1)) lerr++;
        if (win_last) done = 1'b1;
        got++;
      end
      @(negedge clk);
    end
    win_ready = 1'b0;
    check({tag, " window data"}, 128'(derr), 128'd0);
    check({tag, " win_last position"}, 128'(lerr), 128'd0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int got;
    string tag;
    tag = $sformatf("vec%0d", idx);
    fill_set(v);
    if (v.err != 0) begin
      check({tag, " cfg_err pulse"}, 128'(cfg_err), 128'd1);
      check({tag, " no win_valid"}, 128'(win_valid), 128'd0);
      @(negedge clk);
      check({tag, " cfg_err one cycle, idle"}, 128'({cfg_err, busy, win_valid}), 128'd0);
    end else begin
      consume(v, 0, 200, tag, got);
      check({tag, " window count"}, 128'(got), 128'(v.nwin));
      check({tag, " idle after last"}, 128'({busy, win_valid, fill_ready}), 128'b001);
    end
  endtask

  initial begin
    int got, serr, ferr;
    logic [WW-1:0] held;
    //              k  s  st en ea rm r0v gh nwin err
    tbl[0]  = mk(3, 1, 3, 34, 1, 7, 1, 0, 33, 0);
    tbl[1]  = mk(3, 2, 3, 34, 1, 7, 1, 0, 17, 0);
    tbl[2]  = mk(2, 3, 3, 34, 1, 7, 1, 0, 12, 0);
    tbl[3]  = mk(1, 0, 3, 34, 0, 7, 1, 0, 34, 0);
    tbl[4]  = mk(3, 1, 1, 1,  0, 7, 1, 0, 0,  1);
    tbl[5]  = mk(4, 1, 3, 34, 1, 7, 1, 0, 0,  1);
    tbl[6]  = mk(3, 1, 40, 70, 5, 7, 1, 0, 68, 0);
    tbl[7]  = mk(3, 4, 3, 10, 2, 7, 1, 0, 3,  0);
    tbl[8]  = mk(0, 1, 3, 34, 1, 7, 1, 0, 0,  1);
    tbl[9]  = mk(3, 1, 3, 34, 1, 7, 0, 0, 33, 0);
    tbl[10] = mk(3, 1, 3, 10, 0, 2, 1, 1, 8,  0);

    repeat (2) @(negedge clk);
    check("reset outputs", 128'({fill_ready, win_valid, win_last, cfg_err, busy}), 128'b10000);
    check("reset win_data", 128'(win_data), 128'd0);
    reset = 1'b1;
    @(negedge clk);

    // Window 0 of the base config, hand-computed: c2..c0 = pix0, slab1, slab0 per row.
    fill_set(tbl[0]);
    check("vec0 window0 literal", 128'(win_data), 128'h81_f2_e2_41_f1_e1_01_f0_e0);
    consume(tbl[0], 0, 200, "vec0 lit", got);

    for (int i = 0; i < 11; i++) run_vec(tbl[i], i);

    // Mid-stream stall: output must hold while not accepted.
    fill_set(tbl[1]);
    consume(tbl[1], 0, 3, "stall pre", got);
    check("stall pre count", 128'(got), 128'd3);
    held = win_data;
    check("stall held window", 128'(held), 128'(exp_win(tbl[1], 3)));
    serr = 0;
    repeat (5) begin
      @(negedge clk);
      if (win_data !== held || win_valid !== 1'b1) serr++;
    end
    check("stall data stable", 128'(serr), 128'd0);
`ifdef ROW_BANK_STALL_CNT_EN
    check("stall_cnt after 5", 128'(stall_cnt), 128'd5);
`endif
    consume(tbl[1], 3, 200, "stall post", got);
    check("stall post count", 128'(got), 128'd14);
    check("stall idle after", 128'({busy, win_valid}), 128'd0);

    // Fill attempts during SHIFT are refused and leave rows intact.
    fill_set(tbl[0]);
    ferr = 0;
    fill_valid = 1'b1; fill_row_sel = 2'd0; fill_row_valid = 1'b1;
    fill_start_idx = 16'd1; fill_end_idx = 16'd32; fill_pixels = '1; fill_last = 1'b1;
    repeat (3) begin
      if (fill_ready !== 1'b0) ferr++;
      @(negedge clk);
    end
    fill_valid = 1'b0; fill_last = 1'b0;
    check("fill_ready low in SHIFT", 128'(ferr), 128'd0);
    consume(tbl[0], 0, 200, "shift fill", got);
    check("shift fill count", 128'(got), 128'd33);

    // Async reset in the middle of SHIFT.
    fill_set(tbl[0]);
    consume(tbl[0], 0, 5, "rst pre", got);
    repeat (2) @(negedge clk);
`ifdef ROW_BANK_STALL_CNT_EN
    check("stall_cnt before reset", 128'(stall_cnt), 128'd2);
`endif
    reset = 1'b0;
    #1;
    check("mid-shift reset outputs", 128'({fill_ready, win_valid, win_last, cfg_err, busy}), 128'b10000);
    check("mid-shift reset win_data", 128'(win_data), 128'd0);
`ifdef ROW_BANK_STALL_CNT_EN
    check("stall_cnt reset", 128'(stall_cnt), 128'd0);
`endif
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post reset idle", 128'({busy, win_valid, fill_ready}), 128'b001);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, limit 400000 reached");
    $fatal(1);
  end

endmodule
